data_mem_arbiter: RTL
=====================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter N_WORDS, default 1024, number of 64-bit words in the attached data memory.
REQ-002 Data/address width SHALL be `XLEN (64); requester index i is 0 (core LSU) or 1 (debug/DMA).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  [1:0]  requester i has a pending request.
REQ-006 req_ready  output  [1:0]  requester i's request is accepted this cycle.
REQ-007 req_we  input  [1:0]  1 = write, 0 = read, per requester.
REQ-008 req_addr0, req_addr1  input  XLEN each  byte address per requester.
REQ-009 req_wdata0, req_wdata1  input  XLEN each  write data per requester.
REQ-010 req_be0, req_be1  input  8 each  byte enables per requester; bit k selects byte k.
REQ-011 rsp_valid  output  [1:0]  response for requester i is available.
REQ-012 rsp_ready  input  [1:0]  requester i consumes the response.
REQ-013 rsp_rdata  output  XLEN  read data, shared, valid only with rsp_valid.
REQ-014 rsp_err  output  1  error flag, shared, valid only with rsp_valid.
REQ-015 mem_we  output  1  write enable to the data memory.
REQ-016 mem_addr  output  XLEN  byte address to the memory; word index = addr bits [XLEN-1:3].
REQ-017 mem_wdata  output  XLEN  merged write data to the memory.
REQ-018 mem_rdata  input  XLEN  combinational read data from the memory.

Function
REQ-019 The block SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-020 IDLE: if any req_valid, the block SHALL grant one requester, assert req_ready for it only (combinationally, same cycle), latch we/addr/wdata/be, and go to ACCESS.
REQ-021 Arbitration SHALL be round-robin: a 1-bit priority pointer names the preferred requester; a lone requester always wins; the pointer flips to the other requester after each completed response.
REQ-022 req_ready SHALL be 0 in ACCESS and RESP; at most one req_ready bit high in any cycle.
REQ-023 ACCESS: mem_addr SHALL equal the latched address; mem_rdata SHALL be captured into rsp_rdata; next state RESP.
REQ-024 Write merge: mem_wdata byte k = latched wdata byte k if be[k] else mem_rdata byte k; mem_we=1 in ACCESS only for a legal write with be != 0.
REQ-025 mem_we SHALL be 0 in every state other than ACCESS.
REQ-026 Illegal request = address bits [2:0] != 0, or word index >= N_WORDS; it SHALL produce no write, rsp_rdata=0, rsp_err=1.
REQ-027 Legal read: rsp_rdata = mem_rdata (full word, independent of be); rsp_err=0; legal write: rsp_rdata = pre-write mem_rdata, rsp_err=0.
REQ-028 RESP: rsp_valid SHALL be high for the granted requester only, with rsp_rdata/rsp_err stable, until that requester's rsp_ready=1; then go to IDLE.
REQ-029 Latency: request accepted at cycle T, memory access at T+1, rsp_valid first high at T+2; minimum 3 cycles per transaction.
REQ-030 rsp_ready for a non-granted requester, or while not in RESP, SHALL be ignored.
REQ-031 Changes to req_* inputs after acceptance SHALL NOT affect the transaction in flight.

Reset
REQ-032 On rst, asynchronously: state=IDLE, priority pointer=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0, latched request cleared.
REQ-033 Reset asserted mid-transaction SHALL abort it; any write not already clocked in ACCESS SHALL NOT occur.

Verification
REQ-034 Requester 0 writes 0x1122334455667788 to addr 0x10, be=0xFF, then reads 0x10 -> rsp_rdata=0x1122334455667788, rsp_err=0, rsp_valid 2 cycles after accept.
REQ-035 Word 0x10 = 0x1122334455667788; requester 1 writes 0xAAAAAAAAAAAAAAAA with be=0x0F -> readback 0x11223344AAAAAAAA.
REQ-036 Both req_valid held high for 4 transactions from reset -> grant order 0,1,0,1; never both req_ready high.
REQ-037 Write to addr 0x13 (misaligned), and to addr N_WORDS*8 -> rsp_err=1, rsp_rdata=0, mem_we never asserted.
REQ-038 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready stays 0 for a new requester.
REQ-039 rst pulsed during ACCESS of a write -> all outputs at reset values immediately; next transaction from requester 0 completes normally.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port 64-bit data memory.
// Each transaction runs IDLE -> ACCESS -> RESP with read-modify-write byte merging.
`ifndef XLEN
`define XLEN 64
`endif

module data_mem_arbiter #(
  parameter int N_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [`XLEN-1:0]  req_addr0,
  input  logic [`XLEN-1:0]  req_addr1,
  input  logic [`XLEN-1:0]  req_wdata0,
  input  logic [`XLEN-1:0]  req_wdata1,
  input  logic [7:0]        req_be0,
  input  logic [7:0]        req_be1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [`XLEN-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [`XLEN-1:0]  mem_addr,
  output logic [`XLEN-1:0]  mem_wdata,
  input  logic [`XLEN-1:0]  mem_rdata
);
  localparam int XLEN = `XLEN;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state, state_next;
  logic             ptr;
  logic             gnt;
  logic             gnt_q;
  logic             we_q;
  logic [XLEN-1:0]  addr_q;
  logic [XLEN-1:0]  wdata_q;
  logic [7:0]       be_q;
  logic             legal;
  logic [XLEN-1:0]  merged;

  // A lone requester always wins; on contention the pointer decides.
  always_comb begin
    gnt = ptr;
    if (req_valid == 2'b01) gnt = 1'b0;
    else if (req_valid == 2'b10) gnt = 1'b1;
  end

  assign legal    = (addr_q[2:0] == 3'b000) && ((addr_q >> 3) < XLEN'(N_WORDS));
  assign mem_addr = addr_q;

  always_comb begin
    merged = mem_rdata;
    for (int k = 0; k < 8; k++) begin
      if (be_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // req_ready is also masked by rst so it reads 0 the moment reset is raised.
  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if ((|req_valid) && !rst) begin
          req_ready  = gnt ? 2'b10 : 2'b01;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_we     = we_q && legal && (|be_q);
        mem_wdata  = merged;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = gnt_q ? 2'b10 : 2'b01;
        if (rsp_ready[gnt_q]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 1'b0;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == IDLE && (|req_valid)) begin
        gnt_q   <= gnt;
        we_q    <= req_we[gnt];
        addr_q  <= gnt ? req_addr1  : req_addr0;
        wdata_q <= gnt ? req_wdata1 : req_wdata0;
        be_q    <= gnt ? req_be1    : req_be0;
      end
      if (state == ACCESS) begin
        rsp_rdata <= legal ? mem_rdata : '0;
        rsp_err   <= !legal;
      end
      if (state == RESP && rsp_ready[gnt_q]) ptr <= ~ptr;
    end
  end
endmodule
